// File: rtl/nor_vector_checker_if.sv
// Bundle between the gate sequencer/checker and the gate it exercises.
// slave  : the checker side (takes start and gate_out, drives stimulus and results).
// master : the environment side (drives start and gate_out, observes everything else).
interface nor_vector_checker_if;
    logic       start;        // run request
    logic       gate_out;     // output of the gate under check
    logic       input_1;      // gate input A = vector index bit 1
    logic       input_2;      // gate input B = vector index bit 0
    logic       busy;         // run in progress
    logic       done;         // run finished, held until restart/reset
    logic       pass;         // done with zero mismatches
    logic [7:0] error_count;  // saturating mismatch count
    logic       fail_valid;   // a first failure has been captured
    logic [1:0] fail_vector;  // index of the first failing vector

    modport slave (
        input  start, gate_out,
        output input_1, input_2, busy, done, pass,
               error_count, fail_valid, fail_vector
    );

    modport master (
        output start, gate_out,
        input  input_1, input_2, busy, done, pass,
               error_count, fail_valid, fail_vector
    );
endinterface

// File: rtl/nor_vector_checker.sv
// Purpose: walks a 2-input gate through all four input vectors, compares each
//          sampled output with TRUTH_TABLE and reports count/first-fail/pass.
// Latency: done rises 4*LOOPS*(SETTLE_CYCLES+1) edges after the start edge.
// Backpressure: none; start is only accepted in IDLE or DONE, dropped while busy.
// Ports: clk, reset (sync, active-high) plus nor_vector_checker_if.slave bus
//        carrying start/gate_out in and stimulus, status and results out.
module nor_vector_checker #(
    parameter logic [3:0]  TRUTH_TABLE   = 4'b0001,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    nor_vector_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Counter reload gives SETTLE_CYCLES cycles in SETTLE (counts down to 0 inclusive).
    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LOOP_LAST     = 8'(LOOPS - 1);

    state_t     state_q,  state_d;
    logic [1:0] idx_q,    idx_d;
    logic [7:0] loop_q,   loop_d;
    logic [3:0] cnt_q,    cnt_d;
    logic [7:0] err_q,    err_d;
    logic       fvalid_q, fvalid_d;
    logic [1:0] fvec_q,   fvec_d;
    logic       in1_q,    in1_d;
    logic       in2_q,    in2_d;
    logic       busy_q,   busy_d;
    logic       done_q,   done_d;
    logic       pass_q,   pass_d;
    logic       mismatch;

    // gate_out only matters during the single CHECK cycle.
    assign mismatch = (state_q == S_CHECK) && (bus.gate_out != TRUTH_TABLE[idx_q]);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        loop_d   = loop_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fvalid_d = fvalid_q;
        fvec_d   = fvec_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_SETTLE;
                    idx_d    = 2'd0;
                    loop_d   = 8'd0;
                    cnt_d    = SETTLE_RELOAD;
                    err_d    = 8'd0;
                    fvalid_d = 1'b0;
                    fvec_d   = 2'd0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    // Keep only the first failure of the run.
                    if (!fvalid_q) begin
                        fvalid_d = 1'b1;
                        fvec_d   = idx_q;
                    end
                end
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = SETTLE_RELOAD;
                    state_d = S_SETTLE;
                end else if (loop_q != LOOP_LAST) begin
                    idx_d   = 2'd0;
                    loop_d  = loop_q + 8'd1;
                    cnt_d   = SETTLE_RELOAD;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with
        // the state they describe; inputs therefore change only when entering SETTLE.
        busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == 8'd0);
        in1_d  = busy_d ? idx_d[1] : 1'b0;
        in2_d  = busy_d ? idx_d[0] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            loop_q   <= 8'd0;
            cnt_q    <= 4'd0;
            err_q    <= 8'd0;
            fvalid_q <= 1'b0;
            fvec_q   <= 2'd0;
            in1_q    <= 1'b0;
            in2_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            loop_q   <= loop_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            fvec_q   <= fvec_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.input_1     = in1_q;
    assign bus.input_2     = in2_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.error_count = err_q;
    assign bus.fail_valid  = fvalid_q;
    assign bus.fail_vector = fvec_q;

endmodule

// File: tb/tb_nor_vector_checker.sv
module tb_nor_vector_checker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Gate models: 0 = NOR, 1 = stuck at 0, 2 = OR, 3 = stuck at 1
    logic [1:0] mode_r  [4];
    logic       start_r [4];

    function automatic logic gate_fn(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return ~(a | b);
            2'd1:    return 1'b0;
            2'd2:    return a | b;
            default: return 1'b1;
        endcase
    endfunction

    nor_vector_checker_if i0 ();
    nor_vector_checker_if i1 ();
    nor_vector_checker_if i2 ();
    nor_vector_checker_if i3 ();

    nor_vector_checker                                  u0 (.clk(clk), .reset(reset), .bus(i0.slave));
    nor_vector_checker #(.LOOPS(70))                    u1 (.clk(clk), .reset(reset), .bus(i1.slave));
    nor_vector_checker #(.LOOPS(100))                   u2 (.clk(clk), .reset(reset), .bus(i2.slave));
    nor_vector_checker #(.SETTLE_CYCLES(1))             u3 (.clk(clk), .reset(reset), .bus(i3.slave));

    assign i0.start = start_r[0];
    assign i1.start = start_r[1];
    assign i2.start = start_r[2];
    assign i3.start = start_r[3];
    assign i0.gate_out = gate_fn(mode_r[0], i0.input_1, i0.input_2);
    assign i1.gate_out = gate_fn(mode_r[1], i1.input_1, i1.input_2);
    assign i2.gate_out = gate_fn(mode_r[2], i2.input_1, i2.input_2);
    assign i3.gate_out = gate_fn(mode_r[3], i3.input_1, i3.input_2);

    // Flattened views so the monitor and checks can index by DUT number.
    logic [3:0] done_w, busy_w, pass_w, fval_w, in1_w, in2_w;
    logic [7:0] err_w  [4];
    logic [1:0] fvec_w [4];
    assign done_w = {i3.done, i2.done, i1.done, i0.done};
    assign busy_w = {i3.busy, i2.busy, i1.busy, i0.busy};
    assign pass_w = {i3.pass, i2.pass, i1.pass, i0.pass};
    assign fval_w = {i3.fail_valid, i2.fail_valid, i1.fail_valid, i0.fail_valid};
    assign in1_w  = {i3.input_1, i2.input_1, i1.input_1, i0.input_1};
    assign in2_w  = {i3.input_2, i2.input_2, i1.input_2, i0.input_2};
    assign err_w[0] = i0.error_count;  assign fvec_w[0] = i0.fail_vector;
    assign err_w[1] = i1.error_count;  assign fvec_w[1] = i1.fail_vector;
    assign err_w[2] = i2.error_count;  assign fvec_w[2] = i2.fail_vector;
    assign err_w[3] = i3.error_count;  assign fvec_w[3] = i3.fail_vector;

    typedef struct {
        int dut;
        int cyc;
        int err;
        int fvalid;
        int fvec;
        int pass;
    } exp_t;

    exp_t exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: on every rising done, pop the oldest expectation and compare.
    logic [3:0] done_p = 4'b0;
    exp_t e;
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (done_w[d] && !done_p[d]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: dut %0d rose done at cycle %0d, expected none", d, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_dut",    d,              e.dut);
                    chk("done_cycle",  cyc,            e.cyc);
                    chk("error_count", int'(err_w[d]), e.err);
                    chk("fail_valid",  int'(fval_w[d]), e.fvalid);
                    if (e.fvalid != 0) chk("fail_vector", int'(fvec_w[d]), e.fvec);
                    chk("pass",        int'(pass_w[d]), e.pass);
                end
            end
        end
        done_p <= done_w;
    end

    // Pulses start on DUT d; returns the start edge number t. Call at a negedge.
    task automatic launch(input int d, input int lat, input int err, input int fvalid,
                          input int fvec, input int pass, input bit expect_done,
                          output int t);
        exp_t x;
        start_r[d] = 1'b1;
        t = cyc + 1;
        if (expect_done) begin
            x.dut = d; x.cyc = t + lat; x.err = err;
            x.fvalid = fvalid; x.fvec = fvec; x.pass = pass;
            exp_q.push_back(x);
        end
        @(negedge clk);
        start_r[d] = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d expected done events still pending at cycle %0d", exp_q.size(), cyc);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Checks the input vector walk right after launch (we sit at the negedge after edge T).
    task automatic check_seq(input int d, input int hold);
        for (int j = 0; j < 4 * hold; j++) begin
            chk("seq_input_1", int'(in1_w[d]), ((j / hold) >> 1) & 1);
            chk("seq_input_2", int'(in2_w[d]), (j / hold) & 1);
            chk("seq_busy",    int'(busy_w[d]), 1);
            @(negedge clk);
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        chk({tag, "_busy"},  int'(busy_w[d]), 0);
        chk({tag, "_done"},  int'(done_w[d]), 0);
        chk({tag, "_pass"},  int'(pass_w[d]), 0);
        chk({tag, "_err"},   int'(err_w[d]),  0);
        chk({tag, "_fval"},  int'(fval_w[d]), 0);
        chk({tag, "_fvec"},  int'(fvec_w[d]), 0);
        chk({tag, "_in1"},   int'(in1_w[d]),  0);
        chk({tag, "_in2"},   int'(in2_w[d]),  0);
    endtask

    int t;

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 4; d++) begin
            start_r[d] = 1'b0;
            mode_r[d]  = 2'd0;
        end
        repeat (3) @(negedge clk);
        check_zero(0, "rst_d0");
        check_zero(3, "rst_d3");
        reset = 1'b0;
        @(negedge clk);

        // Correct NOR, defaults: 00,01,10,11 each held 3 cycles, done at T+12.
        mode_r[0] = 2'd0;
        launch(0, 12, 0, 0, 0, 1, 1'b1, t);
        check_seq(0, 3);
        wait_drain(100);

        // Stuck at 0: only vector 0 (expects 1) mismatches.
        mode_r[0] = 2'd1;
        launch(0, 12, 1, 1, 0, 0, 1'b1, t);
        wait_drain(100);

        // OR model: every vector mismatches.
        mode_r[0] = 2'd2;
        launch(0, 12, 4, 1, 0, 0, 1'b1, t);
        wait_drain(100);
        chk("or_done_held", int'(done_w[0]), 1);
        // Restart from DONE clears results immediately.
        launch(0, 12, 4, 1, 0, 0, 1'b1, t);
        chk("restart_err_clr",  int'(err_w[0]),  0);
        chk("restart_fval_clr", int'(fval_w[0]), 0);
        chk("restart_done_clr", int'(done_w[0]), 0);
        wait_drain(100);

        // Stuck at 1, 70 loops: vectors 1,2,3 fail each loop -> 210; done at 4*70*3.
        mode_r[1] = 2'd3;
        launch(1, 840, 210, 1, 1, 0, 1'b1, t);
        wait_drain(1500);

        // Stuck at 1, 100 loops: 300 mismatches saturate at 255.
        mode_r[2] = 2'd3;
        launch(2, 1200, 255, 1, 1, 0, 1'b1, t);
        wait_drain(1500);

        // Start re-pulsed at T+4 is ignored: done still at T+12.
        mode_r[0] = 2'd0;
        launch(0, 12, 0, 0, 0, 1, 1'b1, t);
        while (cyc < t + 3) @(negedge clk);
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        wait_drain(100);

        // Reset sampled at T+5 mid-run (error already counted) wipes everything.
        mode_r[0] = 2'd1;
        launch(0, 0, 0, 0, 0, 0, 1'b0, t);
        while (cyc < t + 4) @(negedge clk);
        chk("pre_reset_err", int'(err_w[0]), 1);
        reset = 1'b1;
        @(negedge clk);
        check_zero(0, "midrun_rst");
        reset = 1'b0;
        @(negedge clk);
        mode_r[0] = 2'd0;
        launch(0, 12, 0, 0, 0, 1, 1'b1, t);
        wait_drain(100);

        // SETTLE_CYCLES=1: each vector held 2 cycles, done at T+8.
        mode_r[3] = 2'd0;
        launch(3, 8, 0, 0, 0, 1, 1'b1, t);
        check_seq(3, 2);
        wait_drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nor_vector_checker.md
Name: nor_vector_checker

Overview:
- Self-sequencing stimulus and check stage that wraps a 2-input gate (default: the Nor gate).
- Drives `input_1`/`input_2` through all four input combinations and holds each vector for a settle window.
- Samples the gate output and compares it against a parameterised truth table.
- Reports mismatch count, first failing vector, done and pass; replaces hand-timed stimulus with a clocked, repeatable sequencer.

Parameters:
- `TRUTH_TABLE`, 4'b0001, expected gate output per vector index; bit k = expected output for index k. Default is NOR.
- `SETTLE_CYCLES`, 2, cycles each vector is held before checking; legal range 1..15.
- `LOOPS`, 1, number of full 4-vector passes per run; legal range 1..255.

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  run request; accepted only in IDLE or DONE
- `gate_out`  in  1  output of the gate under check
- `input_1`  out  1  gate input A = vector index bit 1
- `input_2`  out  1  gate input B = vector index bit 0
- `busy`  out  1  high in SETTLE and CHECK
- `done`  out  1  high in DONE; held until next accepted start or reset
- `pass`  out  1  `done` AND (`error_count` == 0)
- `error_count`  out  8  mismatches this run; saturates at 255
- `fail_valid`  out  1  at least one mismatch captured this run
- `fail_vector`  out  2  index of first mismatch this run

Behaviour:
- Reset, sampled at a clock edge:
  - state = IDLE.
  - All outputs 0.
  - Vector index, loop counter and settle counter cleared.
- Reset has priority over every other event, including mid-run. No partial result survives.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE, with `start`=1:
  - Go to SETTLE.
  - index = 0, loop = 0, settle counter = SETTLE_CYCLES-1.
  - `error_count`, `fail_valid`, `fail_vector` and `done` all clear.
- SETTLE:
  - `input_1`/`input_2` hold the current index bits.
  - Counter decrements each cycle; at 0, go to CHECK.
  - SETTLE therefore occupies exactly SETTLE_CYCLES cycles.
- CHECK (one cycle): `gate_out` is compared with `TRUTH_TABLE[index]`. On mismatch:
  - `error_count` increments, saturating at 255.
  - If `fail_valid`=0: `fail_vector` = index and `fail_valid` = 1. Later mismatches do not overwrite.
- Leaving CHECK:
  - index < 3: index+1, counter reloaded, go to SETTLE.
  - index = 3 and loop < LOOPS-1: index wraps to 0, loop+1, go to SETTLE.
  - Otherwise: go to DONE.
- Vector order per loop: (0,0), (0,1), (1,0), (1,1) as (`input_1`, `input_2`).
- Inputs change only on the edge entering SETTLE; they are stable throughout SETTLE and CHECK.
- In IDLE and DONE, `input_1` = `input_2` = 0.
- Latency: start accepted at edge T, so vector k of loop L enters SETTLE at edge T + (4L+k)(SETTLE_CYCLES+1). DONE is entered at edge T + 4·LOOPS·(SETTLE_CYCLES+1).
- Defaults give done at T+12.
- `start` while busy is ignored; no queuing.
- `start` in DONE restarts immediately with all results cleared.
- `gate_out` is sampled only in CHECK; its value in any other state has no effect.
- The final CHECK result is visible in `error_count` and fail fields in the same cycle `done` first rises.

Test Plan:
- Correct NOR model, defaults, start pulse at edge T → inputs sequence 00,01,10,11, each held 3 cycles. `done`=1 at T+12, `pass`=1, `error_count`=0, `fail_valid`=0.
- `gate_out` stuck at 0, defaults → `error_count`=1, `fail_valid`=1, `fail_vector`=0, `pass`=0.
- OR model (inverted NOR), defaults → `error_count`=4, `fail_vector`=0. Second start from DONE clears results and again ends with 4.
- `gate_out` stuck at 1 with LOOPS=70 → `error_count`=210, `fail_vector`=1. With LOOPS=100 → `error_count` saturates at 255. Done edge matches the latency formula.
- `start` re-pulsed at T+4 → no effect, `done` still at T+12. `reset` asserted at T+5 → next cycle all outputs 0, `input_1`=`input_2`=0, IDLE. A new start then completes normally.
- SETTLE_CYCLES=1, correct NOR → each vector held 2 cycles, `done` at T+8, `pass`=1.
